// File: rtl/fft_axis_pkg.sv
// Shared types and helpers for the AXI4-Stream frame source.
package fft_axis_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STREAM,
        GAP,
        DONE
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 512;

    // Effective frame length: 0 and anything past the buffer depth mean a full buffer.
    function automatic int unsigned eff_len(input int unsigned fl, input int unsigned depth);
        return ((fl == 0) || (fl > depth)) ? depth : fl;
    endfunction

endpackage

// File: rtl/axis_src_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module axis_src_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axis_frame_source.sv
// AXI4-Stream frame source: streams buffer contents or a ramp as framed beats.
// A generator issues sample indices, a one-cycle read stage turns them into
// beats, and a 2-entry FIFO presents them to the sink under backpressure.
module axis_frame_source
    import fft_axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NFRM_W = 16,
    parameter int GAP_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [ADDR_W:0]     frame_len,
    input  logic [NFRM_W-1:0]   num_frames,
    input  logic [GAP_W-1:0]    gap_cycles,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
    output logic                M_AXIS_TLAST,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic                busy,
    output logic                done,
    output logic [NFRM_W-1:0]   frame_cnt
);

    localparam int HALF_W = DATA_W / 2;
    localparam int RD_LAT = 1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_t            state, state_nxt;

    logic              cfg_mode;
    logic [ADDR_W:0]   cfg_len;
    logic [NFRM_W-1:0] cfg_nfrm;
    logic [GAP_W-1:0]  cfg_gap;
    logic              stop_q;
    logic [GAP_W-1:0]  gap_cnt;

    logic [ADDR_W-1:0] gen_k;
    logic [NFRM_W-1:0] gen_frm;
    logic              gen_done;
    logic              gen_last;
    logic              issue;

    logic [RD_LAT:0]   vld_pipe;
    logic [ADDR_W-1:0] s1_k;
    logic              s1_last;
    logic [DATA_W-1:0] ram_q;
    logic [HALF_W-1:0] ramp_r;
    beat_t             beat_in;

    beat_t             fifo [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    beat_t             head;

    logic start_acc, run_st, tvalid, pop, push, tlast_hs, stop_pend, last_frm;

    assign start_acc = (state == IDLE) && start;
    assign run_st    = (state == FETCH) || (state == STREAM) || (state == GAP);
    assign head      = fifo[rd_ptr];
    // Beats are only shown in STREAM, so a prefetched next frame stays hidden during GAP.
    assign tvalid    = (state == STREAM) && (fifo_cnt != 2'd0);
    assign pop       = tvalid && M_AXIS_TREADY;
    assign tlast_hs  = pop && head.last;
    assign stop_pend = stop_q || stop;
    assign last_frm  = (cfg_nfrm != '0) && ((frame_cnt + NFRM_W'(1)) == cfg_nfrm);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = run_st;
        done      = (state == DONE);
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH:  state_nxt = STREAM;
            STREAM: if (tlast_hs) begin
                        if (last_frm || stop_pend) state_nxt = DONE;
                        else if (cfg_gap != '0)    state_nxt = GAP;
                    end
            GAP:    if (stop_pend)           state_nxt = DONE;
                    else if (gap_cnt == '0)  state_nxt = STREAM;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Run configuration, stop latch, gap timer and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode  <= 1'b0;
            cfg_len   <= '0;
            cfg_nfrm  <= '0;
            cfg_gap   <= '0;
            stop_q    <= 1'b0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else if (start_acc) begin
            cfg_mode  <= mode;
            cfg_len   <= (ADDR_W+1)'(eff_len(32'(frame_len), DEPTH));
            cfg_nfrm  <= num_frames;
            cfg_gap   <= gap_cycles;
            stop_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (run_st && stop) stop_q <= 1'b1;
            if (tlast_hs) frame_cnt <= frame_cnt + NFRM_W'(1);
            if ((state == STREAM) && (state_nxt == GAP)) gap_cnt <= cfg_gap - GAP_W'(1);
            else if ((state == GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Issue a read whenever FIFO plus in-flight beats (net of this cycle's pop) leave room.
    assign gen_last    = ({1'b0, gen_k} == (cfg_len - (ADDR_W+1)'(1)));
    assign issue       = run_st && !gen_done &&
                         (({1'b0, fifo_cnt} + {2'b0, vld_pipe[1]}) < (3'd2 + {2'b0, pop}));
    assign vld_pipe[0] = issue;

    // Sample index generator; wraps per frame and stops after the last requested frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_k    <= '0;
            gen_frm  <= '0;
            gen_done <= 1'b0;
        end else if (start_acc) begin
            gen_k    <= '0;
            gen_frm  <= '0;
            gen_done <= 1'b0;
        end else if (issue) begin
            if (gen_last) begin
                gen_k   <= '0;
                gen_frm <= gen_frm + NFRM_W'(1);
                if ((cfg_nfrm != '0) && ((gen_frm + NFRM_W'(1)) == cfg_nfrm)) gen_done <= 1'b1;
            end else begin
                gen_k <= gen_k + ADDR_W'(1);
            end
        end
    end

    // Read stage: valid pipe alongside the index and last flag of the issued sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[RD_LAT:1] <= '0;
            s1_k               <= '0;
            s1_last            <= 1'b0;
        end else begin
            vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
            if (issue) begin
                s1_k    <= gen_k;
                s1_last <= gen_last;
            end
        end
    end

    axis_src_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && (state == IDLE)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (issue),
        .raddr (gen_k),
        .rdata (ram_q)
    );

    assign ramp_r       = HALF_W'(s1_k) + HALF_W'(1);
    assign beat_in.last = s1_last;
    assign beat_in.data = cfg_mode ? {ramp_r, {HALF_W{1'b0}}} : ram_q;
    // Beats arriving after the run ended are discarded.
    assign push         = vld_pipe[RD_LAT] && run_st;

    // Output skid FIFO; flushed when the run ends so prefetched beats never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (!run_st) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= beat_in;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tvalid ? head.data : '0;
    assign M_AXIS_TLAST  = tvalid && head.last;
    assign M_AXIS_TSTRB  = {(DATA_W/8){tvalid}};

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source with a queue-based expected-beat model.
module tb_axis_frame_source;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int NFRM_W = 16;
    localparam int GAP_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start, stop, mode;
    logic [ADDR_W:0]   frame_len;
    logic [NFRM_W-1:0] num_frames;
    logic [GAP_W-1:0]  gap_cycles;
    logic [DATA_W-1:0] tdata;
    logic [3:0]        tstrb;
    logic              tlast, tvalid, tready;
    logic              busy, done;
    logic [NFRM_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    axis_frame_source #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NFRM_W(NFRM_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .mode(mode),
        .frame_len(frame_len), .num_frames(num_frames), .gap_cycles(gap_cycles),
        .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_beat_t;

    int          tests = 0;
    int          fails = 0;
    exp_beat_t   exp_q [$];
    logic [31:0] rx_d [$];
    int          hs_cyc [$];
    logic [31:0] mem_model [DEPTH];
    int          cyc = 0;
    int          done_cnt = 0;
    bit          rnd_ready = 1'b0;
    int          start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Random sink readiness when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) tready = 1'($urandom_range(0, 1));
        end
    end

    // Compare process: AXI stability rules and every handshake against the model.
    initial begin
        logic        prev_stall;
        logic [31:0] pd;
        logic        pl;
        exp_beat_t   e;
        prev_stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 64'(tvalid), 64'(1));
                chk("hold_data", 64'(tdata), 64'(pd));
                chk("hold_last", 64'(tlast), 64'(pl));
            end
            if (tvalid && tready) begin
                chk("tstrb", 64'(tstrb), 64'(4'hF));
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got data %0h with no beat expected", tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(tdata), 64'(e.d));
                    chk("beat_last", 64'(tlast), 64'(e.l));
                end
                rx_d.push_back(tdata);
                hs_cyc.push_back(cyc);
            end
            prev_stall = tvalid && !tready;
            pd = tdata;
            pl = tlast;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prepare();
        exp_q.delete();
        rx_d.delete();
        hs_cyc.delete();
        done_cnt = 0;
    endtask

    // Expected ramp frames: R = k+1, I = 0, last on k = len-1.
    task automatic add_ramp(input int len, input int nfrm);
        exp_beat_t b;
        for (int f = 0; f < nfrm; f++)
            for (int k = 0; k < len; k++) begin
                b.d = {16'(k + 1), 16'h0000};
                b.l = (k == len - 1);
                exp_q.push_back(b);
            end
    endtask

    task automatic add_buf(input int len, input int nfrm);
        exp_beat_t b;
        for (int f = 0; f < nfrm; f++)
            for (int k = 0; k < len; k++) begin
                b.d = mem_model[k];
                b.l = (k == len - 1);
                exp_q.push_back(b);
            end
    endtask

    task automatic start_run(input logic m, input int fl, input int nf, input int gp, input logic with_stop);
        mode       = m;
        frame_len  = (ADDR_W+1)'(fl);
        num_frames = NFRM_W'(nf);
        gap_cycles = GAP_W'(gp);
        start      = 1'b1;
        stop       = with_stop;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int t;
        t = 0;
        while (done_cnt == 0 && t < budget) begin
            tick();
            t++;
        end
        if (done_cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles, beats left %0d", nm, budget, exp_q.size());
        end
        tick(4);
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int t;
        t = 0;
        while (rx_d.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (rx_d.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d beats, needed %0d", nm, rx_d.size(), n);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; mode = 1'b0;
        frame_len = '0; num_frames = '0; gap_cycles = '0; tready = 1'b1;
        tick(3);
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_tlast", 64'(tlast), 64'(0));
        chk("rst_tstrb", 64'(tstrb), 64'(0));
        chk("rst_tdata", 64'(tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        rst_n = 1'b1;
        tick(2);

        // Load buffer[i] = {i, -i}.
        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i] = {16'(i), 16'(-i)};
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = mem_model[i];
            tick();
        end
        wr_en = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;   // stop in IDLE has no effect
        tick(2);

        // Ramp, len 64, two back-to-back frames; a start and a write land mid-run.
        prepare();
        add_ramp(64, 2);
        start_run(1'b1, 64, 2, 0, 1'b0);
        tick(20);
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done("ramp64", 400);
        chk("ramp64_count", 64'(rx_d.size()), 64'(128));
        chk("ramp64_left", 64'(exp_q.size()), 64'(0));
        if (rx_d.size() == 128) begin
            chk("ramp64_latency", 64'(hs_cyc[0] - start_cyc), 64'(3));
            chk("ramp64_span", 64'(hs_cyc[127] - hs_cyc[0]), 64'(127));
            chk("ramp64_first", 64'(rx_d[0]), 64'(32'h0001_0000));
            chk("ramp64_b64", 64'(rx_d[63]), 64'(32'h0040_0000));
            chk("ramp64_b65", 64'(rx_d[64]), 64'(32'h0001_0000));
        end
        chk("ramp64_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("ramp64_done", 64'(done_cnt), 64'(1));
        chk("ramp64_busy", 64'(busy), 64'(0));

        // Buffer, len 0 means full depth, one frame.
        prepare();
        add_buf(512, 1);
        start_run(1'b0, 0, 1, 0, 1'b0);
        wait_done("buf512", 1200);
        chk("buf512_count", 64'(rx_d.size()), 64'(512));
        if (rx_d.size() == 512) begin
            chk("buf512_b0", 64'(rx_d[0]), 64'(32'h0000_0000));
            chk("buf512_b1", 64'(rx_d[1]), 64'(32'h0001_FFFF));
            chk("buf512_b511", 64'(rx_d[511]), 64'(32'h01FF_FE01));
            chk("buf512_span", 64'(hs_cyc[511] - hs_cyc[0]), 64'(511));
        end
        chk("buf512_frame_cnt", 64'(frame_cnt), 64'(1));

        // Same frame with a randomly stalling sink.
        prepare();
        add_buf(512, 1);
        rnd_ready = 1'b1;
        start_run(1'b0, 0, 1, 0, 1'b0);
        wait_done("stall", 6000);
        rnd_ready = 1'b0;
        tready = 1'b1;
        chk("stall_count", 64'(rx_d.size()), 64'(512));
        chk("stall_left", 64'(exp_q.size()), 64'(0));
        chk("stall_done", 64'(done_cnt), 64'(1));

        // Ramp, len 4, three frames, 5-cycle gaps; stop with start is ignored.
        prepare();
        add_ramp(4, 3);
        start_run(1'b1, 4, 3, 5, 1'b1);
        wait_done("gap", 200);
        chk("gap_count", 64'(rx_d.size()), 64'(12));
        if (rx_d.size() == 12) begin
            chk("gap_frame1", 64'(hs_cyc[3] - hs_cyc[0]), 64'(3));
            chk("gap_after_f1", 64'(hs_cyc[4] - hs_cyc[3]), 64'(6));
            chk("gap_after_f2", 64'(hs_cyc[8] - hs_cyc[7]), 64'(6));
        end
        chk("gap_frame_cnt", 64'(frame_cnt), 64'(3));

        // len 1: every beat is a TLAST beat.
        prepare();
        add_ramp(1, 3);
        start_run(1'b1, 1, 3, 0, 1'b0);
        wait_done("len1", 100);
        chk("len1_count", 64'(rx_d.size()), 64'(3));
        if (rx_d.size() == 3) chk("len1_span", 64'(hs_cyc[2] - hs_cyc[0]), 64'(2));
        chk("len1_frame_cnt", 64'(frame_cnt), 64'(3));

        // Oversized length clamps to depth.
        prepare();
        add_ramp(512, 1);
        start_run(1'b1, 700, 1, 0, 1'b0);
        wait_done("len700", 1200);
        chk("len700_count", 64'(rx_d.size()), 64'(512));
        if (rx_d.size() == 512) chk("len700_last", 64'(rx_d[511]), 64'(32'h0200_0000));

        // Continuous ramp, stop during frame 2.
        prepare();
        add_ramp(8, 2);
        start_run(1'b1, 8, 0, 0, 1'b0);
        wait_beats("cont", 11, 100);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_done("cont", 100);
        chk("cont_count", 64'(rx_d.size()), 64'(16));
        chk("cont_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("cont_busy", 64'(busy), 64'(0));
        chk("cont_done", 64'(done_cnt), 64'(1));

        // Reset in the middle of a frame, then a buffer run.
        prepare();
        add_ramp(64, 1);
        start_run(1'b1, 64, 1, 0, 1'b0);
        wait_beats("mid_rst", 10, 100);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'(0));
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_tvalid", 64'(tvalid), 64'(0));
        prepare();
        add_buf(16, 1);
        start_run(1'b0, 16, 1, 0, 1'b0);
        wait_done("post_rst", 100);
        chk("post_rst_count", 64'(rx_d.size()), 64'(16));
        if (rx_d.size() == 16) chk("post_rst_b5", 64'(rx_d[5]), 64'(32'h0005_FFFB));
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
